// File: rtl/divider_control.sv
// Sequencing FSM for the restoring shift-subtract divider: drives the Remainder
// register controls and counts WIDTH quotient iterations.
module divider_control #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             divisor_zero,
    input  logic             alu_sign,
    output logic             busy,
    output logic             load_sel,
    output logic             wrctrl,
    output logic             ozctrl,
    output logic             shift_en,
    output logic             ready_wait,
    output logic             ready,
    output logic             done,
    output logic             dz_error,
    output logic [CNT_W-1:0] iter
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT0 = 3'd2;
    localparam logic [2:0] S_TEST   = 3'd3;
    localparam logic [2:0] S_SHIFT  = 3'd4;
    localparam logic [2:0] S_FIX    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_DZ     = 3'd7;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             q_bit_q, q_bit_d;
    logic             dz_error_q, dz_error_d;
    logic             done_first_q, done_first_d;
    logic             accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            iter_q       <= '0;
            q_bit_q      <= 1'b0;
            dz_error_q   <= 1'b0;
            done_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_q       <= iter_d;
            q_bit_q      <= q_bit_d;
            dz_error_q   <= dz_error_d;
            done_first_q <= done_first_d;
        end
    end

    // Next-state and output decode; only wrctrl in TEST depends on an input.
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        q_bit_d    = q_bit_q;
        dz_error_d = dz_error_q;
        busy       = 1'b0;
        load_sel   = 1'b0;
        wrctrl     = 1'b0;
        ozctrl     = 1'b0;
        shift_en   = 1'b0;
        ready_wait = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;
        accept     = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IDLE: begin
                if (start) state_d = divisor_zero ? S_DZ : S_LOAD;
            end
            S_DZ: begin
                busy       = 1'b1;
                done       = 1'b1;
                dz_error_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_LOAD: begin
                busy     = 1'b1;
                load_sel = 1'b1;
                wrctrl   = 1'b1;
                state_d  = S_SHIFT0;
            end
            S_SHIFT0: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                state_d  = S_TEST;
            end
            S_TEST: begin
                busy    = 1'b1;
                wrctrl  = ~alu_sign;
                q_bit_d = ~alu_sign;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                ozctrl   = q_bit_q;
                if (iter_q == LAST_ITER) begin
                    state_d = S_FIX;
                end else begin
                    iter_d  = iter_q + CNT_W'(1);
                    state_d = S_TEST;
                end
            end
            S_FIX: begin
                busy       = 1'b1;
                ready_wait = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                ready      = 1'b1;
                ready_wait = 1'b1;
                done       = done_first_q;
                if (start) state_d = divisor_zero ? S_DZ : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            dz_error_d = 1'b0;
            iter_d     = '0;
        end
        done_first_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    assign dz_error = dz_error_q;
    assign iter     = iter_q;

endmodule

// File: tb/tb_divider_control.sv
// Self-checking bench for divider_control: cycle-phase reference plus a
// behavioural Remainder/ALU datapath that turns the control strobes into a result.
module tb_divider_control;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CNT_W  = 6;
    localparam int          DONE_M = 2 * WIDTH + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic divisor_zero = 1'b0;
    logic alu_sign = 1'b0;
    logic busy, load_sel, wrctrl, ozctrl, shift_en, ready_wait, ready, done, dz_error;
    logic [CNT_W-1:0] iter;

    int checks = 0;
    int errors = 0;

    logic [64:0] rem;
    logic        q_hist [WIDTH];
    int          wr_cnt, sh_cnt, zero_tests;

    divider_control #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .divisor_zero(divisor_zero),
        .alu_sign(alu_sign), .busy(busy), .load_sel(load_sel), .wrctrl(wrctrl),
        .ozctrl(ozctrl), .shift_en(shift_en), .ready_wait(ready_wait),
        .ready(ready), .done(done), .dz_error(dz_error), .iter(iter)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] ctl();
        return {busy, load_sel, wrctrl, shift_en, ready_wait, ready, done};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full divide; mode 0 = ALU model drives alu_sign, 1 = held 1, 2 = held 0, 3 = random.
    task automatic run_div(input logic [31:0] dividend, input logic [31:0] divisor,
                           input int mode, input bit repulse, input bit check_result);
        logic       a_s;
        logic [6:0] exp;
        int         k;
        @(negedge clk);
        start = 1'b1;
        divisor_zero = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        rem = '0;
        wr_cnt = 0;
        sh_cnt = 0;
        zero_tests = 0;
        a_s = 1'b0;
        for (int m = 0; m <= DONE_M + 1; m++) begin
            if (m > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            k = (m - 2) / 2;
            divisor_zero = 1'($urandom_range(0, 1));
            if (m >= 2 && m <= 2 * WIDTH && (m % 2) == 0) begin
                case (mode)
                    0:       a_s = (rem[64:32] < {1'b0, divisor});
                    1:       a_s = 1'b1;
                    2:       a_s = 1'b0;
                    default: a_s = 1'($urandom_range(0, 1));
                endcase
                alu_sign = a_s;
                q_hist[k] = ~a_s;
                if (!a_s) zero_tests++;
            end else begin
                alu_sign = 1'($urandom_range(0, 1));
            end
            @(negedge clk);

            if (m == 0)                    exp = 7'b1110000;
            else if (m == 1)               exp = 7'b1001000;
            else if (m <= 2 * WIDTH + 1)   exp = ((m % 2) == 0) ? {2'b10, ~a_s, 4'b0000} : 7'b1001000;
            else if (m == 2 * WIDTH + 2)   exp = 7'b1000100;
            else if (m == DONE_M)          exp = 7'b0000111;
            else                           exp = 7'b0000110;
            check($sformatf("ctl m=%0d", m), 64'(ctl()), 64'(exp));
            check($sformatf("dz_error m=%0d", m), 64'(dz_error), 64'(0));

            if (m == 1)
                check("ozctrl shift0", 64'(ozctrl), 64'(0));
            else if (m >= 3 && m <= 2 * WIDTH + 1 && (m % 2) == 1)
                check($sformatf("ozctrl m=%0d", m), 64'(ozctrl), 64'(q_hist[k]));

            if (m <= 1)
                check($sformatf("iter m=%0d", m), 64'(iter), 64'(0));
            else if (m <= 2 * WIDTH + 1)
                check($sformatf("iter m=%0d", m), 64'(iter), 64'(k));
            else if (m == 2 * WIDTH + 2)
                check("iter fix", 64'(iter), 64'(WIDTH - 1));

            if (wrctrl && load_sel) rem = {33'd0, dividend};
            else if (wrctrl)        rem[64:32] = rem[64:32] - {1'b0, divisor};
            if (shift_en)           rem = {rem[63:0], ozctrl};
            if (ready_wait && busy) rem[64:32] = rem[64:32] >> 1;
            if (wrctrl)   wr_cnt++;
            if (shift_en) sh_cnt++;

            if (repulse && (m == 9 || m == 39)) start = 1'b1;
        end
        divisor_zero = 1'b0;
        check("wrctrl count", 64'(wr_cnt), 64'(1 + zero_tests));
        check("shift_en count", 64'(sh_cnt), 64'(WIDTH + 1));
        if (check_result) begin
            check($sformatf("quotient %0h/%0h", dividend, divisor), 64'(rem[31:0]), 64'(dividend / divisor));
            check($sformatf("remainder %0h/%0h", dividend, divisor), 64'(rem[63:32]), 64'(dividend % divisor));
        end
    endtask

    task automatic run_dz();
        @(negedge clk);
        start = 1'b1;
        divisor_zero = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        divisor_zero = 1'b0;
        @(negedge clk);
        check("dz ctl", 64'(ctl()), 64'(7'b1000001));
        check("dz flag in DZ", 64'(dz_error), 64'(0));
        @(posedge clk); #1;
        divisor_zero = 1'b1;
        @(negedge clk);
        check("dz idle ctl", 64'(ctl()), 64'(0));
        check("dz flag set", 64'(dz_error), 64'(1));
        check("dz idle iter", 64'(iter), 64'(0));
        @(posedge clk); #1;
        divisor_zero = 1'b0;
        @(negedge clk);
        check("dz flag sticky", 64'(dz_error), 64'(1));
        check("dz idle ctl2", 64'(ctl()), 64'(0));
    endtask

    initial begin
        logic [31:0] a, b;

        // Power-on reset and first IDLE cycle.
        #2;
        check("reset ctl", 64'(ctl()), 64'(0));
        check("reset iter", 64'(iter), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle ctl", 64'(ctl()), 64'(0));
        check("idle dz", 64'(dz_error), 64'(0));

        run_div(32'h1234_5678, 32'h9, 1, 1'b0, 1'b0);
        run_div(32'h0, 32'h1, 2, 1'b0, 1'b0);
        run_div(32'd12, 32'd4, 0, 1'b0, 1'b1);
        run_div(32'd100, 32'd7, 0, 1'b1, 1'b1);
        run_div(32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b1);
        run_div(32'd5, 32'd9, 0, 1'b0, 1'b1);
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            run_div(a, b, 0, 1'($urandom_range(0, 1)), 1'b1);
        end
        run_div($urandom, 32'd3, 3, 1'b0, 1'b0);

        // Divide-by-zero from DONE, cleared by the next accepted start.
        run_dz();
        run_div(32'd77, 32'd5, 0, 1'b0, 1'b1);
        run_dz();

        // Asynchronous reset while idle clears the sticky flag.
        #2;
        rst = 1'b0;
        #1;
        check("reset clears dz", 64'(dz_error), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset in the middle of a TEST cycle.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        alu_sign = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check("pre-reset wrctrl", 64'(wrctrl), 64'(1));
        rst = 1'b0;
        #1;
        check("async reset ctl", 64'(ctl()), 64'(0));
        check("async reset oz", 64'(ozctrl), 64'(0));
        check("async reset iter", 64'(iter), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("post-reset ctl %0d", i), 64'(ctl()), 64'(0));
            check($sformatf("post-reset iter %0d", i), 64'(iter), 64'(0));
            check($sformatf("post-reset dz %0d", i), 64'(dz_error), 64'(0));
        end

        run_div(32'd1000, 32'd33, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_control.md
Name: divider_control

Overview:
Sequencing FSM for the restoring shift-subtract divider. It drives the control inputs of the Remainder register: load select, wrctrl, ozctrl, the shift enable, ready_wait and ready. It reads the sign of the ALU difference (remainder upper half minus divisor) and steps through WIDTH iterations. It sits between the divide-request logic and the Remainder/ALU datapath.

Parameters:
WIDTH, 32, operand width; number of quotient iterations
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  divide request, sampled in IDLE or DONE
divisor_zero  input  1  divisor==0 flag, sampled together with an accepted start
alu_sign  input  1  MSB of ALU difference (Remainder upper half - divisor); meaningful only in TEST
busy  output  1  operation in progress
load_sel  output  1  Remainder_input mux: 1=dividend, 0=ALU difference into upper half
wrctrl  output  1  Remainder write strobe for the current edge
ozctrl  output  1  bit inserted at the Remainder LSB on shift
shift_en  output  1  Remainder shift-left on the current edge
ready_wait  output  1  final upper-half shift-right cycle
ready  output  1  result valid; held high while in DONE
done  output  1  one-cycle completion pulse
dz_error  output  1  divide-by-zero flag; sticky until next accepted start
iter  output  CNT_W  current iteration index, 0..WIDTH-1

Behaviour:
- Reset (rst=0, any time, including mid-operation): state=IDLE, iter=0, q_bit=0, dz_error=0. All outputs are 0 while rst=0 and in the first IDLE cycle after release.
- States are IDLE, LOAD, SHIFT0, TEST, SHIFT, FIX, DONE, DZ.
- IDLE: all outputs 0 except dz_error, which keeps its value.
  - start=1, divisor_zero=1 -> DZ.
  - start=1, divisor_zero=0 -> LOAD.
  - An accepted start clears dz_error.
- DZ (1 cycle): busy=1, done=1, dz_error set at exit. No wrctrl or shift_en. -> IDLE.
- LOAD (1 cycle): busy=1, load_sel=1, wrctrl=1. -> SHIFT0.
- SHIFT0 (1 cycle): busy=1, shift_en=1, ozctrl=0, iter=0. -> TEST.
- TEST (1 cycle): busy=1. Mealy outputs load_sel=0, wrctrl=~alu_sign. q_bit<=~alu_sign. -> SHIFT.
- SHIFT (1 cycle): busy=1, shift_en=1, ozctrl=q_bit.
  - iter==WIDTH-1 -> FIX, iter holds.
  - Otherwise iter<=iter+1 -> TEST.
- FIX (1 cycle): busy=1, ready_wait=1. -> DONE.
- DONE: ready=1, ready_wait=1, busy=0. done=1 only in the first DONE cycle.
  - start=1 is accepted exactly as in IDLE; the next state has ready=0.
  - start=0 stays in DONE.
- Latency: the edge that samples start is E0. DONE is entered at edge E0+2*WIDTH+3, i.e. E0+67 for WIDTH=32.
  - wrctrl pulses per operation = 1 + (number of TEST cycles with alu_sign=0).
  - shift_en pulses = WIDTH+1.
- start while busy=1 is ignored; it is not queued.
- alu_sign is ignored outside TEST. divisor_zero is ignored except with an accepted start.
- At most one of wrctrl and shift_en is high in any cycle.
- ready and busy are never high together.
- Outputs other than wrctrl/load_sel in TEST are decoded from registered state only.

Test Plan:
1. Reset: assert rst=0 during a TEST cycle of a running divide -> all outputs 0 immediately (asynchronous). After release: IDLE, iter=0, dz_error=0, no spurious wrctrl.
2. alu_sign held 1, start pulse -> wrctrl only in LOAD. shift_en=33 pulses, all with ozctrl=0. ready_wait at edge 66, ready/done at edge 67, done low at edge 68, ready still 1.
3. alu_sign held 0 -> wrctrl=33 pulses, with load_sel=0 on the 32 in TEST. ozctrl=0 on SHIFT0 and 1 on all 32 SHIFT pulses. iter steps 0..31.
4. Integration with Remainder and ALU: 12/4 -> Quotient_output=3, Remainder_output=0. 100/7 -> 14, 2. 0xFFFFFFFF/1 -> 0xFFFFFFFF, 0. 5/9 -> 0, 5.
5. start with divisor_zero=1 -> one cycle of busy=1, done=1, then dz_error=1 in IDLE. No wrctrl or shift_en. The next accepted start clears dz_error.
6. start re-pulsed at edges 10 and 40 of an operation -> ignored, completion still at edge 67. start asserted in DONE -> ready drops next edge, LOAD entered, new result at +67.
